// File: rtl/rat_ckpt_pkg.sv
// Shared defaults and per-cycle action encoding for the rename alias table.
package rat_ckpt_pkg;
  localparam int DEF_NUM_AREGS = 8;
  localparam int DEF_ROB_DEPTH = 4;

  typedef enum logic [1:0] {
    ACT_NORMAL  = 2'd0,
    ACT_FLUSH   = 2'd1,
    ACT_RESTORE = 2'd2
  } rat_act_e;
endpackage

// File: rtl/rat_bank.sv
// NUM_AREGS x {valid, rob} table: tag-checked clear, one write port, parallel load.
// rd exposes the table with this cycle's commit already applied.
module rat_bank
  import rat_ckpt_pkg::*;
#(
  parameter  int NUM_AREGS = DEF_NUM_AREGS,
  parameter  int ROB_W     = 2,
  localparam int AREG_W    = $clog2(NUM_AREGS),
  localparam int EW        = ROB_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_all,
  input  logic                          load_en,
  input  logic [NUM_AREGS-1:0][EW-1:0]  load_data,
  input  logic                          clr_en,
  input  logic [AREG_W-1:0]             clr_idx,
  input  logic [ROB_W-1:0]              clr_rob,
  input  logic                          wr_en,
  input  logic [AREG_W-1:0]             wr_idx,
  input  logic [ROB_W-1:0]              wr_rob,
  output logic [NUM_AREGS-1:0][EW-1:0]  rd
);
  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob;
  } rat_entry_t;

  for (genvar i = 0; i < NUM_AREGS; i++) begin : g_ent
    rat_entry_t ent, clr, nxt;

    always_comb begin
      clr = ent;
      // Only the exact producer may retire a mapping; a younger rename survives.
      if (clr_en && clr_idx == AREG_W'(i) && ent.rob == clr_rob) clr.valid = 1'b0;
      nxt = clr;
      if (clear_all)                          nxt = '0;
      else if (load_en)                       nxt = rat_entry_t'(load_data[i]);
      else if (wr_en && wr_idx == AREG_W'(i)) nxt = '{valid: 1'b1, rob: wr_rob};
    end

    always_ff @(posedge clk or posedge rst)
      if (rst) ent <= '0;
      else     ent <= nxt;

    assign rd[i] = clr;
  end
endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with tag-checked commit, flush and a single branch checkpoint.
// Live and snapshot tables are rat_bank instances; priority, read mux and occupancy live here.
module rat_ckpt
  import rat_ckpt_pkg::*;
#(
  parameter  int NUM_AREGS = DEF_NUM_AREGS,
  parameter  int ROB_DEPTH = DEF_ROB_DEPTH,
  localparam int AREG_W    = $clog2(NUM_AREGS),
  localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_en,
  input  logic [AREG_W-1:0] dest_reg,
  input  logic [ROB_W-1:0]  rob_tail,
  input  logic              commit_en,
  input  logic [AREG_W-1:0] commit_reg,
  input  logic [ROB_W-1:0]  commit_rob,
  input  logic              flush,
  input  logic              ckpt_save,
  input  logic              ckpt_restore,
  input  logic [AREG_W-1:0] src1_reg,
  input  logic [AREG_W-1:0] src2_reg,
  output logic              src1_ready,
  output logic              src2_ready,
  output logic [ROB_W-1:0]  src1_rob,
  output logic [ROB_W-1:0]  src2_rob,
  output logic              ckpt_valid,
  output logic [AREG_W:0]   pending_count
);
  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob;
  } rat_entry_t;

  rat_entry_t [NUM_AREGS-1:0] live_rd, snap_rd;
  rat_act_e                   act;
  logic [AREG_W:0]            cnt_nxt;

  always_comb begin
    act = ACT_NORMAL;
    if (flush || (ckpt_restore && !ckpt_valid)) act = ACT_FLUSH;
    else if (ckpt_restore)                      act = ACT_RESTORE;
  end

  rat_bank #(.NUM_AREGS(NUM_AREGS), .ROB_W(ROB_W)) u_live (
    .clk       (clk),
    .rst       (rst),
    .clear_all (act == ACT_FLUSH),
    .load_en   (act == ACT_RESTORE),
    .load_data (snap_rd),
    .clr_en    (commit_en),
    .clr_idx   (commit_reg),
    .clr_rob   (commit_rob),
    .wr_en     (update_en && act == ACT_NORMAL),
    .wr_idx    (dest_reg),
    .wr_rob    (rob_tail),
    .rd        (live_rd)
  );

  // Snapshot takes live after commit but before this cycle's rename.
  rat_bank #(.NUM_AREGS(NUM_AREGS), .ROB_W(ROB_W)) u_snap (
    .clk       (clk),
    .rst       (rst),
    .clear_all (1'b0),
    .load_en   (ckpt_save && act == ACT_NORMAL),
    .load_data (live_rd),
    .clr_en    (commit_en),
    .clr_idx   (commit_reg),
    .clr_rob   (commit_rob),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_rob    ('0),
    .rd        (snap_rd)
  );

  // live_rd already has the commit match cleared, which is exactly the retire bypass.
  assign src1_ready = !live_rd[src1_reg].valid;
  assign src2_ready = !live_rd[src2_reg].valid;
  assign src1_rob   = live_rd[src1_reg].rob;
  assign src2_rob   = live_rd[src2_reg].rob;

  always_comb begin
    logic v;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_AREGS; i++) begin
      unique case (act)
        ACT_FLUSH:   v = 1'b0;
        ACT_RESTORE: v = snap_rd[i].valid;
        default:     v = live_rd[i].valid || (update_en && dest_reg == AREG_W'(i));
      endcase
      cnt_nxt = cnt_nxt + {{AREG_W{1'b0}}, v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ckpt_valid    <= 1'b0;
      pending_count <= '0;
    end else begin
      pending_count <= cnt_nxt;
      if (act != ACT_NORMAL) ckpt_valid <= 1'b0;
      else if (ckpt_save)    ckpt_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt at 16 arch regs / 8 ROB entries: directed scenarios plus a
// randomized run against a behavioural model through a scoreboard queue.
module tb_rat_ckpt;
  localparam int NA = 16;
  localparam int RD = 8;
  localparam int AW = 4;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          update_en = 0, commit_en = 0, flush = 0, ckpt_save = 0, ckpt_restore = 0;
  logic [AW-1:0] dest_reg = 0, commit_reg = 0, src1_reg = 0, src2_reg = 0;
  logic [RW-1:0] rob_tail = 0, commit_rob = 0;
  logic          src1_ready, src2_ready, ckpt_valid;
  logic [RW-1:0] src1_rob, src2_rob;
  logic [AW:0]   pending_count;

  int total = 0;
  int bad   = 0;

  bit          mv [NA];
  logic [RW-1:0] mr [NA];
  bit          sv [NA];
  logic [RW-1:0] sr [NA];
  bit          mck;

  typedef struct {bit r1; logic [RW-1:0] b1; bit r2; logic [RW-1:0] b2;} exp_t;
  exp_t sb[$];

  rat_ckpt #(.NUM_AREGS(NA), .ROB_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .update_en(update_en), .dest_reg(dest_reg), .rob_tail(rob_tail),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_rob(commit_rob), .flush(flush),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_ready(src1_ready), .src2_ready(src2_ready), .src1_rob(src1_rob), .src2_rob(src2_rob),
    .ckpt_valid(ckpt_valid), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < NA; i++) begin mv[i] = 0; mr[i] = 0; sv[i] = 0; sr[i] = 0; end
    mck = 0;
  endfunction

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < NA; i++) c += mv[i];
    return c;
  endfunction

  function automatic bit exp_ready(input logic [AW-1:0] s);
    return !mv[s] || (commit_en && commit_reg == s && mr[s] == commit_rob);
  endfunction

  function automatic void model_step();
    if (flush || (ckpt_restore && !mck)) begin
      for (int i = 0; i < NA; i++) mv[i] = 0;
      mck = 0;
    end else if (ckpt_restore) begin
      for (int i = 0; i < NA; i++) begin
        mv[i] = sv[i] && !(commit_en && commit_reg == i && sr[i] == commit_rob);
        mr[i] = sr[i];
      end
      mck = 0;
    end else begin
      if (commit_en) begin
        if (mv[commit_reg] && mr[commit_reg] == commit_rob) mv[commit_reg] = 0;
        if (sv[commit_reg] && sr[commit_reg] == commit_rob) sv[commit_reg] = 0;
      end
      if (ckpt_save) begin
        for (int i = 0; i < NA; i++) begin sv[i] = mv[i]; sr[i] = mr[i]; end
        mck = 1;
      end
      if (update_en) begin mv[dest_reg] = 1; mr[dest_reg] = rob_tail; end
    end
  endfunction

  task automatic idle();
    update_en = 0; commit_en = 0; flush = 0; ckpt_save = 0; ckpt_restore = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle();
  endtask

  task automatic upd(input int r, input int t);
    update_en = 1; dest_reg = AW'(r); rob_tail = RW'(t);
  endtask

  task automatic test_reset();
    src1_reg = 4'd3; src2_reg = 4'd9;
    #1;
    total++; if (src1_ready !== 1'b1 || src2_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b exp=11", src1_ready, src2_ready); end
    total++; if (src1_rob !== 3'd0 || src2_rob !== 3'd0) begin bad++; $display("FAIL reset_rob got=%0d/%0d exp=0/0", src1_rob, src2_rob); end
    total++; if (ckpt_valid !== 1'b0 || pending_count !== 5'd0) begin bad++; $display("FAIL reset_regs got=%b/%0d exp=0/0", ckpt_valid, pending_count); end
  endtask

  task automatic test_rename_commit();
    upd(3, 2); tick();
    src1_reg = 4'd3;
    #1;
    total++; if (src1_ready !== 1'b0 || src1_rob !== 3'd2) begin bad++; $display("FAIL rename_read got=%b/%0d exp=0/2", src1_ready, src1_rob); end
    total++; if (pending_count !== 5'd1) begin bad++; $display("FAIL rename_pending got=%0d exp=1", pending_count); end
    commit_en = 1; commit_reg = 4'd3; commit_rob = 3'd2;
    #1;
    total++; if (src1_ready !== 1'b1) begin bad++; $display("FAIL commit_bypass got=%b exp=1", src1_ready); end
    tick();
    total++; if (pending_count !== 5'd0 || src1_ready !== 1'b1) begin bad++; $display("FAIL commit_after got=%0d/%b exp=0/1", pending_count, src1_ready); end
  endtask

  task automatic test_stale_commit();
    upd(3, 1); tick();
    upd(3, 3); tick();
    commit_en = 1; commit_reg = 4'd3; commit_rob = 3'd1; tick();
    src1_reg = 4'd3;
    #1;
    total++; if (src1_ready !== 1'b0 || src1_rob !== 3'd3) begin bad++; $display("FAIL stale_commit got=%b/%0d exp=0/3", src1_ready, src1_rob); end
    flush = 1; tick();
  endtask

  task automatic test_checkpoint();
    upd(1, 0); tick();
    ckpt_save = 1; upd(2, 1); tick();
    total++; if (ckpt_valid !== 1'b1 || pending_count !== 5'd2) begin bad++; $display("FAIL ckpt_save got=%b/%0d exp=1/2", ckpt_valid, pending_count); end
    upd(1, 2); tick();
    src1_reg = 4'd1;
    #1;
    total++; if (src1_rob !== 3'd2) begin bad++; $display("FAIL ckpt_rename got=%0d exp=2", src1_rob); end
    ckpt_restore = 1; tick();
    src1_reg = 4'd1; src2_reg = 4'd2;
    #1;
    total++; if (src1_ready !== 1'b0 || src1_rob !== 3'd0 || src2_ready !== 1'b1) begin bad++; $display("FAIL ckpt_restore got=%b/%0d/%b exp=0/0/1", src1_ready, src1_rob, src2_ready); end
    total++; if (ckpt_valid !== 1'b0 || pending_count !== 5'd1) begin bad++; $display("FAIL ckpt_restore_regs got=%b/%0d exp=0/1", ckpt_valid, pending_count); end
    flush = 1; tick();
  endtask

  task automatic test_commit_during_ckpt();
    upd(1, 0); tick();
    ckpt_save = 1; tick();
    commit_en = 1; commit_reg = 4'd1; commit_rob = 3'd0; tick();
    ckpt_restore = 1; tick();
    src1_reg = 4'd1;
    #1;
    total++; if (src1_ready !== 1'b1 || pending_count !== 5'd0) begin bad++; $display("FAIL ckpt_commit got=%b/%0d exp=1/0", src1_ready, pending_count); end
    upd(6, 4); tick();
    ckpt_restore = 1; tick();
    src1_reg = 4'd6;
    #1;
    total++; if (src1_ready !== 1'b1 || pending_count !== 5'd0 || ckpt_valid !== 1'b0) begin bad++; $display("FAIL restore_empty got=%b/%0d/%b exp=1/0/0", src1_ready, pending_count, ckpt_valid); end
  endtask

  task automatic test_same_cycle();
    upd(4, 5); tick();
    flush = 1; upd(4, 6); tick();
    src1_reg = 4'd4;
    #1;
    total++; if (src1_ready !== 1'b1 || pending_count !== 5'd0) begin bad++; $display("FAIL flush_update got=%b/%0d exp=1/0", src1_ready, pending_count); end
    upd(5, 1); tick();
    commit_en = 1; commit_reg = 4'd5; commit_rob = 3'd1; upd(5, 2); tick();
    src1_reg = 4'd5;
    #1;
    total++; if (src1_ready !== 1'b0 || src1_rob !== 3'd2 || pending_count !== 5'd1) begin bad++; $display("FAIL commit_update got=%b/%0d/%0d exp=0/2/1", src1_ready, src1_rob, pending_count); end
  endtask

  task automatic test_random();
    exp_t e, g;
    for (int n = 0; n < 800; n++) begin
      update_en    = ($urandom_range(3) != 0);
      dest_reg     = AW'($urandom_range(NA-1));
      rob_tail     = RW'($urandom_range(RD-1));
      commit_en    = ($urandom_range(1) == 1);
      commit_reg   = AW'($urandom_range(NA-1));
      commit_rob   = ($urandom_range(2) != 0) ? mr[commit_reg] : RW'($urandom_range(RD-1));
      flush        = ($urandom_range(31) == 0);
      ckpt_save    = ($urandom_range(7) == 0);
      ckpt_restore = ($urandom_range(15) == 0);
      src1_reg     = AW'($urandom_range(NA-1));
      src2_reg     = ($urandom_range(3) == 0) ? commit_reg : AW'($urandom_range(NA-1));
      e.r1 = exp_ready(src1_reg); e.b1 = mr[src1_reg];
      e.r2 = exp_ready(src2_reg); e.b2 = mr[src2_reg];
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      total++; if (src1_ready !== g.r1 || (!g.r1 && src1_rob !== g.b1)) begin bad++; $display("FAIL rand_src1 n=%0d got=%b/%0d exp=%b/%0d", n, src1_ready, src1_rob, g.r1, g.b1); end
      total++; if (src2_ready !== g.r2 || (!g.r2 && src2_rob !== g.b2)) begin bad++; $display("FAIL rand_src2 n=%0d got=%b/%0d exp=%b/%0d", n, src2_ready, src2_rob, g.r2, g.b2); end
      tick();
      total++; if (ckpt_valid !== mck || pending_count !== (AW+1)'(mcount())) begin bad++; $display("FAIL rand_regs n=%0d got=%b/%0d exp=%b/%0d", n, ckpt_valid, pending_count, mck, mcount()); end
    end
  endtask

  task automatic test_reset_mid();
    upd(2, 3); tick();
    upd(9, 5); ckpt_save = 1; tick();
    src1_reg = 4'd2; src2_reg = 4'd9;
    upd(7, 6); commit_en = 1; commit_reg = 4'd2; commit_rob = 3'd1;
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    total++; if (src1_ready !== 1'b1 || src2_ready !== 1'b1 || src1_rob !== 3'd0 || src2_rob !== 3'd0) begin bad++; $display("FAIL midreset_src got=%b%b/%0d/%0d exp=11/0/0", src1_ready, src2_ready, src1_rob, src2_rob); end
    total++; if (ckpt_valid !== 1'b0 || pending_count !== 5'd0) begin bad++; $display("FAIL midreset_regs got=%b/%0d exp=0/0", ckpt_valid, pending_count); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    upd(2, 4); tick();
    src1_reg = 4'd2;
    #1;
    total++; if (src1_ready !== 1'b0 || src1_rob !== 3'd4 || pending_count !== 5'd1) begin bad++; $display("FAIL post_reset got=%b/%0d/%0d exp=0/4/1", src1_ready, src1_rob, pending_count); end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_rename_commit();
    test_stale_commit();
    test_checkpoint();
    test_commit_during_ckpt();
    test_same_cycle();
    flush = 1; tick();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
